// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: receive-side counterpart of a VGA timing generator.
// Recovers horizontal/vertical position from active-low hSync/vSync,
// checks line and frame timing against the parameters, and while locked
// emits one registered pixel per clock with its column/row coordinates.
//
// Ports:
//   clock25Mhz                 pixel clock, all logic on its rising edge
//   reset                      asynchronous, active-high reset
//   hSync, vSync               active-low sync inputs
//   redIN, greenIN, blueIN     8-bit pixel data inputs
//   column, row                coordinates of the current output pixel
//   redOUT, greenOUT, blueOUT  registered pixel data, 0 when not valid
//   pixelValid                 output pixel lies in the active area
//   frameStart                 one-clock pulse coincident with pixel (0,0)
//   locked                     high while timing is locked
//   errorCount                 saturating count of timing errors
module vga_sync_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_TOTAL  = 525
) (
  input  logic       clock25Mhz,
  input  logic       reset,
  input  logic       hSync,
  input  logic       vSync,
  input  logic [7:0] redIN,
  input  logic [7:0] greenIN,
  input  logic [7:0] blueIN,
  output logic [9:0] column,
  output logic [9:0] row,
  output logic [7:0] redOUT,
  output logic [7:0] greenOUT,
  output logic [7:0] blueOUT,
  output logic       pixelValid,
  output logic       frameStart,
  output logic       locked,
  output logic [7:0] errorCount
);

  localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [9:0] H_LINE  = 10'(H_TOTAL);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state;
  state_t     state_nx;
  logic       err_inc;
  logic       hsync_p0;
  logic       vsync_p0;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       vpend;

  logic h_fall;
  logic v_fall;
  logic frame_bnd;
  logic line_err;
  logic frame_err;
  logic loss_err;
  logic h_win;
  logic v_win;

  // A vSync fall on the same clock as the hSync fall closes the frame
  // immediately; a mid-line fall is remembered until the next hSync fall.
  assign h_fall    = hsync_p0 & ~hSync;
  assign v_fall    = vsync_p0 & ~vSync;
  assign frame_bnd = vpend | v_fall;

  assign line_err  = h_fall && (hcnt != H_LINE);
  assign frame_err = h_fall && frame_bnd && (vcnt != V_LAST);
  // Flags only on the clock the counter steps onto its ceiling.
  assign loss_err  = !h_fall && (hcnt == CNT_MAX - 10'd1);

  assign h_win = (hcnt >= H_START) && (hcnt <= H_END);
  assign v_win = (vcnt >= V_START) && (vcnt <= V_END);

  // lineErr outranks the others; any error costs one increment.
  always_comb begin
    state_nx = state;
    err_inc  = 1'b0;
    unique case (state)
      SEARCH: begin
        if (h_fall && frame_bnd) state_nx = CHECK;
      end
      CHECK: begin
        if (line_err || loss_err) begin
          state_nx = SEARCH;
          err_inc  = 1'b1;
        end else if (h_fall && frame_bnd) begin
          if (frame_err) err_inc  = 1'b1;
          else           state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (line_err || frame_err || loss_err) begin
          state_nx = SEARCH;
          err_inc  = 1'b1;
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  // Stage p0: sync edge detection, position counters, lock state
  always_ff @(posedge clock25Mhz or posedge reset) begin
    if (reset) begin
      hsync_p0   <= 1'b1;
      vsync_p0   <= 1'b1;
      hcnt       <= '0;
      vcnt       <= '0;
      vpend      <= 1'b0;
      state      <= SEARCH;
      locked     <= 1'b0;
      errorCount <= '0;
    end else begin
      hsync_p0 <= hSync;
      vsync_p0 <= vSync;
      if (h_fall) begin
        hcnt  <= 10'd1;
        vcnt  <= frame_bnd ? 10'd0 : sat_inc10(vcnt);
        vpend <= 1'b0;
      end else begin
        hcnt <= sat_inc10(hcnt);
        if (v_fall) vpend <= 1'b1;
      end
      state  <= state_nx;
      locked <= (state_nx == LOCKED);
      if (err_inc) errorCount <= sat_inc8(errorCount);
    end
  end

  // Stage p1: registered pixel output, one clock behind the sampled input
  always_ff @(posedge clock25Mhz or posedge reset) begin
    if (reset) begin
      column     <= '0;
      row        <= '0;
      redOUT     <= '0;
      greenOUT   <= '0;
      blueOUT    <= '0;
      pixelValid <= 1'b0;
      frameStart <= 1'b0;
    end else if ((state == LOCKED) && h_win && v_win) begin
      pixelValid <= 1'b1;
      column     <= hcnt - H_START;
      row        <= vcnt - V_START;
      redOUT     <= redIN;
      greenOUT   <= greenIN;
      blueOUT    <= blueIN;
      frameStart <= (hcnt == H_START) && (vcnt == V_START);
    end else begin
      pixelValid <= 1'b0;
      redOUT     <= '0;
      greenOUT   <= '0;
      blueOUT    <= '0;
      frameStart <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder using a reduced timing (16x10 clocks/lines)
// so whole frames fit in a short run. A line-level reference model predicts
// lock state, error count and the pixel stream; a monitor checks the DUT.
module tb_vga_sync_decoder;

  localparam int HA = 8;
  localparam int HS = 2;
  localparam int HB = 2;
  localparam int HT = 16;
  localparam int VA = 4;
  localparam int VS = 1;
  localparam int VB = 2;
  localparam int VT = 10;

  localparam int M_SEARCH = 0;
  localparam int M_CHECK  = 1;
  localparam int M_LOCKED = 2;

  logic       clk;
  logic       rst;
  logic       hSync;
  logic       vSync;
  logic [7:0] redIN, greenIN, blueIN;
  logic [9:0] column, row;
  logic [7:0] redOUT, greenOUT, blueOUT;
  logic       pixelValid, frameStart, locked;
  logic [7:0] errorCount;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT)
  ) dut (
    .clock25Mhz(clk),
    .reset(rst),
    .hSync(hSync),
    .vSync(vSync),
    .redIN(redIN),
    .greenIN(greenIN),
    .blueIN(blueIN),
    .column(column),
    .row(row),
    .redOUT(redOUT),
    .greenOUT(greenOUT),
    .blueOUT(blueOUT),
    .pixelValid(pixelValid),
    .frameStart(frameStart),
    .locked(locked),
    .errorCount(errorCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;
    int vfall_at;
    int vrise_at;
    int rst_at;
  } line_t;

  typedef struct {
    logic [9:0]  col;
    logic [9:0]  row;
    logic [23:0] rgb;
    logic        fs;
  } pix_t;

  line_t lines[$];
  pix_t  pix_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state (per line, not per clock)
  int m_state;
  int m_err;
  int m_vline;
  int m_prev_len;
  bit m_pend;
  bit next_coinc;

  bit    chk_ctl = 1'b0;
  logic  exp_lock;
  int    exp_errc;
  string chk_name;

  logic [23:0] line_rgb [HA];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state    = M_SEARCH;
    m_err      = 0;
    m_vline    = 0;
    m_prev_len = -1;
    m_pend     = 1'b0;
  endtask

  task automatic model_error();
    m_state = M_SEARCH;
    if (m_err < 255) m_err++;
  endtask

  // Applies the timing rules for the hSync fall that starts line ln.
  task automatic model_hfall(input line_t ln);
    bit b, lerr, ferr;
    b    = (ln.vfall_at == 0) || m_pend;
    lerr = (m_prev_len != HT);
    ferr = b && (m_vline != VT - 1);
    case (m_state)
      M_SEARCH: if (b) m_state = M_CHECK;
      M_CHECK: begin
        if (lerr) model_error();
        else if (b) begin
          if (ferr) begin
            if (m_err < 255) m_err++;
          end else m_state = M_LOCKED;
        end
      end
      default: if (lerr || ferr) model_error();
    endcase
    m_vline    = b ? 0 : ((m_vline < 1023) ? m_vline + 1 : 1023);
    m_pend     = (ln.vfall_at > 0);
    m_prev_len = ln.len;
  endtask

  task automatic arm_ctl_check(input string name);
    exp_lock = (m_state == M_LOCKED);
    exp_errc = m_err;
    chk_name = name;
    chk_ctl  = 1'b1;
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b1;
    #1;
    check("rst_column", 32'(column), 32'd0);
    check("rst_row", 32'(row), 32'd0);
    check("rst_rgb", 32'({redOUT, greenOUT, blueOUT}), 32'd0);
    check("rst_pixelValid", 32'(pixelValid), 32'd0);
    check("rst_frameStart", 32'(frameStart), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_errorCount", 32'(errorCount), 32'd0);
    model_reset();
    pix_q.delete();
    chk_ctl = 1'b0;
    hSync = 1'b1;
    vSync = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Builds one frame of lines; bad_idx gets length bad_len, rst_idx ends
  // the frame early with a reset partway through that line.
  task automatic gen_frame(input int nlines, input bit end_mid, input int bad_idx,
                           input int bad_len, input int rst_idx);
    line_t ln;
    for (int i = 0; i < nlines; i++) begin
      ln.len      = (i == bad_idx) ? bad_len : HT;
      ln.vfall_at = (i == 0 && next_coinc) ? 0 : -1;
      ln.vrise_at = (i == VS) ? 0 : -1;
      ln.rst_at   = -1;
      if (i == nlines - 1 && end_mid) ln.vfall_at = $urandom_range(HT - 2, 1);
      if (i == rst_idx) begin
        ln.rst_at = 7;
        lines.push_back(ln);
        return;
      end
      lines.push_back(ln);
    end
    next_coinc = !end_mid;
  endtask

  task automatic run_lines();
    line_t ln;
    pix_t  p;
    bit    aborted;
    while (lines.size() > 0) begin
      ln = lines.pop_front();
      aborted = 1'b0;
      for (int t = 0; t < ln.len; t++) begin
        @(negedge clk);
        hSync = (t < HS) ? 1'b0 : 1'b1;
        if (ln.vfall_at == t) vSync = 1'b0;
        if (ln.vrise_at == t) vSync = 1'b1;
        if (t >= HS + HB && t < HS + HB + HA) {redIN, greenIN, blueIN} = line_rgb[t - HS - HB];
        else {redIN, greenIN, blueIN} = 24'($urandom);
        if (t == 0) begin
          model_hfall(ln);
          arm_ctl_check("line_start");
        end
        if (t == 1) begin
          for (int c = 0; c < HA; c++) line_rgb[c] = 24'($urandom);
          if (m_state == M_LOCKED && m_vline >= VS + VB && m_vline < VS + VB + VA) begin
            for (int c = 0; c < HA; c++) begin
              p.col = 10'(c);
              p.row = 10'(m_vline - (VS + VB));
              p.rgb = line_rgb[c];
              p.fs  = (c == 0) && (m_vline == VS + VB);
              pix_q.push_back(p);
            end
          end
        end
        if (t == 1022) begin
          if (m_state != M_SEARCH) model_error();
          arm_ctl_check("hcnt_saturate");
        end
        if (ln.rst_at == t) begin
          do_reset();
          aborted = 1'b1;
          break;
        end
      end
      if (aborted) lines.delete();
    end
  endtask

  // monitor: pops expected pixels whenever the DUT presents one
  initial begin
    pix_t p;
    forever begin
      @(posedge clk);
      #1;
      if (pixelValid === 1'b1) begin
        if (pix_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pixel: got pixelValid=1 col=%0d row=%0d expected no pixel at %0t",
                   column, row, $time);
        end else begin
          p = pix_q.pop_front();
          check("pix_column", 32'(column), 32'(p.col));
          check("pix_row", 32'(row), 32'(p.row));
          check("pix_rgb", 32'({redOUT, greenOUT, blueOUT}), 32'(p.rgb));
          check("pix_frameStart", 32'(frameStart), 32'(p.fs));
        end
      end else begin
        check("idle_rgb", 32'({redOUT, greenOUT, blueOUT}), 32'd0);
        check("idle_frameStart", 32'(frameStart), 32'd0);
      end
      if (chk_ctl) begin
        check({chk_name, "_locked"}, 32'(locked), 32'(exp_lock));
        check({chk_name, "_errorCount"}, 32'(errorCount), 32'(exp_errc));
        check({chk_name, "_pixels_left"}, 32'(pix_q.size()), 32'd0);
        chk_ctl = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, bad, blen;
    bit em;
    rst = 1'b1;
    hSync = 1'b1;
    vSync = 1'b1;
    {redIN, greenIN, blueIN} = 24'd0;
    for (int c = 0; c < HA; c++) line_rgb[c] = 24'd0;
    model_reset();
    next_coinc = 1'b1;
    repeat (3) @(negedge clk);
    check("init_locked", 32'(locked), 32'd0);
    check("init_errorCount", 32'(errorCount), 32'd0);
    check("init_pixelValid", 32'(pixelValid), 32'd0);
    check("init_out", 32'({column, row}), 32'd0);
    rst = 1'b0;

    // nominal lock, then a frame closed by a mid-line vSync fall
    gen_frame(VT, 1'b0, -1, HT, -1);
    gen_frame(VT, 1'b0, -1, HT, -1);
    gen_frame(VT, 1'b1, -1, HT, -1);
    gen_frame(VT, 1'b0, -1, HT, -1);
    // long line while locked, then relock
    gen_frame(VT, 1'b0, 4, HT + 1, -1);
    gen_frame(VT, 1'b0, -1, HT, -1);
    gen_frame(VT, 1'b0, -1, HT, -1);
    // lose lock, then a 1100-clock line during CHECK
    gen_frame(VT, 1'b0, 2, HT + 1, -1);
    gen_frame(VT, 1'b0, 3, 1100, -1);
    // short frame during CHECK, then a good one
    gen_frame(VT - 1, 1'b0, -1, HT, -1);
    gen_frame(VT, 1'b0, -1, HT, -1);
    gen_frame(VT, 1'b0, -1, HT, -1);
    // reset partway through a locked frame
    gen_frame(VT, 1'b0, -1, HT, 5);
    run_lines();

    next_coinc = 1'b1;
    gen_frame(VT, 1'b0, -1, HT, -1);
    gen_frame(VT, 1'b0, -1, HT, -1);
    gen_frame(VT, 1'b0, -1, HT, -1);
    run_lines();

    // randomized frames with occasional timing faults
    for (int k = 0; k < 12; k++) begin
      nl   = ($urandom_range(9, 0) == 0) ? (($urandom_range(1, 0) == 1) ? VT + 1 : VT - 1) : VT;
      em   = 1'($urandom_range(1, 0));
      bad  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(nl - 1, 0)) : -1;
      blen = ($urandom_range(1, 0) == 1) ? HT + 1 : HT - 1;
      gen_frame(nl, em, bad, blen, -1);
    end
    gen_frame(VT, 1'b0, -1, HT, -1);
    gen_frame(VT, 1'b0, -1, HT, -1);
    run_lines();

    repeat (4) @(negedge clk);
    check("final_pixels_left", 32'(pix_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
